kt8p_cpu_core: RTL and testbench

//  Parametrised multi-cycle successor of the kt8 accumulator CPU: A/B/R registers, ALU, relative jumps.

---
 rtl/kt8p_cpu_core.sv | 181 ++++++++++++++++++
 tb/tb_kt8p_cpu_core.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kt8p_cpu_core.sv
// kt8p multi-cycle accumulator CPU: A/B/R/P registers, ALU, relative and conditional jumps,
// hardware return stack, data-memory req/ready handshake, HALT and FAULT states.
module kt8p_cpu_core #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        instruction,
  output logic [PC_W-1:0]   code_address,
  output logic [ADDR_W-1:0] data_address,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] ram_out,
  input  logic [DATA_W-1:0] ram_in,
  input  logic              mem_ready,
  output logic              zero,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        dbg_state
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_ALU  = 4'h4;
  localparam logic [3:0] OP_STR  = 4'h5;
  localparam logic [3:0] OP_SETP = 4'h6;
  localparam logic [3:0] OP_JF   = 4'h7;
  localparam logic [3:0] OP_JB   = 4'h8;
  localparam logic [3:0] OP_JFZ  = 4'h9;
  localparam logic [3:0] OP_JBZ  = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_INCP = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PC_W-1:0]   r_pc;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_a, r_b, r_r;
  logic [ADDR_W-1:0] r_p;
  logic              r_z;
  logic [SP_W-1:0]   r_sp;
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];

  logic [3:0]        w_op, w_n;
  logic [PC_W-1:0]   w_k, w_pc_inc;
  logic [DATA_W-1:0] w_alu;
  logic              w_is_mem, w_overflow, w_underflow, w_exec_ok, w_read_done;
  logic [SP_W-1:0]   w_sp_dec;
  logic [IDX_W-1:0]  w_push_idx, w_pop_idx;

  assign w_op        = r_ir[7:4];
  assign w_n         = r_ir[3:0];
  assign w_k         = PC_W'(w_n) + PC_W'(1);
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_is_mem    = (w_op == OP_LDA) || (w_op == OP_LDB) || (w_op == OP_STR);
  assign w_overflow  = (w_op == OP_CALL) && (r_sp == SP_FULL);
  assign w_underflow = (w_op == OP_RET) && (r_sp == '0);
  assign w_exec_ok   = (r_state == S_EXEC) && !w_overflow && !w_underflow;
  assign w_read_done = (r_state == S_MEM) && mem_ready;
  assign w_sp_dec    = r_sp - SP_W'(1);
  assign w_push_idx  = r_sp[IDX_W-1:0];
  assign w_pop_idx   = w_sp_dec[IDX_W-1:0];

  // Handshake: mem_req is high for the whole MEM state; the access completes on the first
  // rising edge where mem_req && mem_ready. Address, direction and write data come from
  // P, IR and R, none of which can change while in MEM, so they are stable by construction.
  assign mem_req      = (r_state == S_MEM);
  assign mem_we       = mem_req && (w_op == OP_STR);
  assign code_address = r_pc;
  assign data_address = r_p;
  assign ram_out      = r_r;
  assign zero         = r_z;
  assign halted       = (r_state == S_HALT);
  assign fault        = (r_state == S_FAULT);
  assign dbg_state    = r_state;

  always_comb begin
    w_alu = '0;
    case (w_n)
      4'h0:    w_alu = r_a + r_b;
      4'h1:    w_alu = r_a - r_b;
      4'h2:    w_alu = r_a & r_b;
      4'h3:    w_alu = r_a | r_b;
      4'h4:    w_alu = r_a ^ r_b;
      4'h5:    w_alu = ~r_a;
      4'h6:    w_alu = r_a << 1;
      4'h7:    w_alu = r_a >> 1;
      4'h8:    w_alu = r_a;
      4'h9:    w_alu = r_b;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (w_overflow || w_underflow) w_state_nxt = S_FAULT;
        else if (w_op == OP_HALT)      w_state_nxt = S_HALT;
        else if (w_is_mem)             w_state_nxt = S_MEM;
        else                           w_state_nxt = S_FETCH;
      end
      S_MEM:   if (mem_ready) w_state_nxt = S_FETCH;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= '0;
      r_ir <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_r  <= '0;
      r_p  <= '0;
      r_z  <= 1'b1;
      r_sp <= '0;
    end else begin
      if (r_state == S_FETCH) r_ir <= instruction;
      if (w_exec_ok) begin
        r_pc <= w_pc_inc;
        case (w_op)
          OP_LDI:  r_b <= DATA_W'(w_n);
          OP_ALU: begin
            r_r <= w_alu;
            r_z <= (w_alu == '0);
          end
          OP_SETP: r_p <= r_r[ADDR_W-1:0];
          OP_JF:   r_pc <= r_pc + w_k;
          OP_JB:   r_pc <= r_pc - w_k;
          OP_JFZ:  if (r_z) r_pc <= r_pc + w_k;
          OP_JBZ:  if (r_z) r_pc <= r_pc - w_k;
          OP_CALL: begin
            r_sp <= r_sp + SP_W'(1);
            r_pc <= r_pc + w_k;
          end
          OP_RET: begin
            r_sp <= w_sp_dec;
            r_pc <= r_stack[w_pop_idx];
          end
          OP_INCP: r_p <= r_p + ADDR_W'(1);
          default: ;
        endcase
      end
      if (w_read_done) begin
        if (w_op == OP_LDA) r_a <= ram_in;
        if (w_op == OP_LDB) r_b <= ram_in;
      end
    end
  end

  // Stack storage needs no reset: entries are only read below SP.
  always_ff @(posedge clk) begin
    if (!rst && w_exec_ok && (w_op == OP_CALL)) r_stack[w_push_idx] <= w_pc_inc;
  end

endmodule

// File: tb/tb_kt8p_cpu_core.sv
// Bench for kt8p_cpu_core: instruction-level reference model, directed scenarios and
// randomized programs with random memory latency; a 16-bit instance covers wide P/R.
module tb_kt8p_cpu_core;

  localparam logic [2:0] ST_FETCH = 3'd0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst2;

  logic [7:0]  instruction, code_address, data_address, ram_out, ram_in;
  logic        mem_req, mem_we, mem_ready, zero, halted, fault;
  logic [2:0]  dbg_state;
  logic [7:0]  rom [256];
  logic [7:0]  env_ram [256];

  logic [7:0]  instruction2, code_address2;
  logic [11:0] data_address2;
  logic [15:0] ram_out2, ram_in2;
  logic        mem_req2, mem_we2, mem_ready2, zero2, halted2, fault2;
  logic [2:0]  dbg_state2;
  logic [7:0]  rom2 [256];
  logic [15:0] ram2 [4096];

  assign instruction  = rom[code_address];
  assign instruction2 = rom2[code_address2];

  kt8p_cpu_core #(.DATA_W(8), .PC_W(8), .ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .code_address(code_address),
    .data_address(data_address), .mem_req(mem_req), .mem_we(mem_we), .ram_out(ram_out),
    .ram_in(ram_in), .mem_ready(mem_ready), .zero(zero), .halted(halted), .fault(fault),
    .dbg_state(dbg_state)
  );

  kt8p_cpu_core #(.DATA_W(16), .PC_W(8), .ADDR_W(12), .STACK_DEPTH(4)) dut16 (
    .clk(clk), .rst(rst2), .instruction(instruction2), .code_address(code_address2),
    .data_address(data_address2), .mem_req(mem_req2), .mem_we(mem_we2), .ram_out(ram_out2),
    .ram_in(ram_in2), .mem_ready(mem_ready2), .zero(zero2), .halted(halted2), .fault(fault2),
    .dbg_state(dbg_state2)
  );

  // reference model (architectural state)
  logic [7:0] m_pc, m_a, m_b, m_r, m_p;
  logic       m_z, m_halt, m_fault;
  logic [7:0] m_stack [$];
  logic [7:0] m_ram [256];

  int checks = 0;
  int errors = 0;
  int force_wait = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] alu_model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    int res;
    case (f)
      4'h0: res = a + b;
      4'h1: res = a - b;
      4'h2: res = a & b;
      4'h3: res = a | b;
      4'h4: res = a ^ b;
      4'h5: res = 255 - a;
      4'h6: res = a * 2;
      4'h7: res = a / 2;
      4'h8: res = a;
      4'h9: res = b;
      default: res = 0;
    endcase
    return res[7:0];
  endfunction

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_r = 0; m_p = 0;
    m_z = 1'b1; m_halt = 1'b0; m_fault = 1'b0;
    m_stack.delete();
  endtask

  task automatic model_exec(input logic [7:0] ins);
    logic [3:0] op, n;
    int k, nxt;
    op = ins[7:4];
    n  = ins[3:0];
    k  = n + 1;
    nxt = m_pc + 1;
    case (op)
      4'h1: m_a = m_ram[m_p];
      4'h2: m_b = m_ram[m_p];
      4'h3: m_b = {4'h0, n};
      4'h4: begin m_r = alu_model(n, m_a, m_b); m_z = (m_r == 8'h00); end
      4'h5: m_ram[m_p] = m_r;
      4'h6: m_p = m_r;
      4'h7: nxt = m_pc + k;
      4'h8: nxt = m_pc - k;
      4'h9: if (m_z) nxt = m_pc + k;
      4'hA: if (m_z) nxt = m_pc - k;
      4'hB: if (m_stack.size() == 4) m_fault = 1'b1;
            else begin m_stack.push_back(m_pc + 8'd1); nxt = m_pc + k; end
      4'hC: if (m_stack.size() == 0) m_fault = 1'b1;
            else nxt = m_stack.pop_back();
      4'hD: m_p = m_p + 8'd1;
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
    if (!m_fault) m_pc = nxt[7:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00; env_ram[i] = 8'h00; m_ram[i] = 8'h00;
    end
  endtask

  // Driver + compare: one instruction (or one idle cycle once halted/faulted), starting and
  // ending on the falling edge of a FETCH cycle.
  task automatic step();
    logic [7:0] ins;
    logic [3:0] op;
    logic       wr;
    int         w;
    if (m_halt || m_fault) begin
      chk("halted", 32'(halted), 32'(m_halt));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("idle_req", 32'(mem_req), 32'(0));
      chk("pc_frozen", 32'(code_address), 32'(m_pc));
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end else begin
      chk("pc", 32'(code_address), 32'(m_pc));
      chk("p", 32'(data_address), 32'(m_p));
      chk("r", 32'(ram_out), 32'(m_r));
      chk("z", 32'(zero), 32'(m_z));
      chk("halted", 32'(halted), 32'(0));
      chk("fault", 32'(fault), 32'(0));
      chk("fetch_req", 32'(mem_req), 32'(0));
      chk("fetch_state", 32'(dbg_state), 32'(ST_FETCH));
      ins = rom[m_pc];
      op  = ins[7:4];
      wr  = (op == 4'h5);
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("exec_req", 32'(mem_req), 32'(0));
      mem_ready = 1'($urandom_range(0, 1));
      if (op == 4'h1 || op == 4'h2 || op == 4'h5) begin
        w = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
        for (int c = 0; c <= w; c++) begin
          @(negedge clk);
          chk("req_held", 32'(mem_req), 32'(1));
          chk("we", 32'(mem_we), 32'(wr));
          chk("addr", 32'(data_address), 32'(m_p));
          if (wr) chk("wdata", 32'(ram_out), 32'(m_r));
          mem_ready = (c == w);
          ram_in = (c == w && !wr) ? env_ram[data_address] : 8'($urandom);
          if (c == w && wr) env_ram[data_address] = ram_out;
        end
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      model_exec(ins);
    end
  endtask

  // memory responder for the 16-bit instance: single-cycle ready
  initial begin
    mem_ready2 = 1'b0;
    ram_in2 = '0;
    forever begin
      @(negedge clk);
      mem_ready2 = mem_req2;
      ram_in2 = ram2[data_address2];
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1; rst2 = 1'b1; mem_ready = 1'b0; ram_in = 8'h00;
    clear_mem();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("reset_pc", 32'(code_address), 32'(0));
    chk("reset_z", 32'(zero), 32'(1));
    chk("reset_req", 32'(mem_req), 32'(0));
    chk("reset_we", 32'(mem_we), 32'(0));

    // LDI 5; LDA (ram[0]=3, two waits); ALU sub; STR
    clear_mem();
    rom[0] = 8'h35; rom[1] = 8'h10; rom[2] = 8'h41; rom[3] = 8'h50; rom[4] = 8'hF0;
    env_ram[0] = 8'h03; m_ram[0] = 8'h03;
    force_wait = 2;
    do_reset();
    repeat (3) step();
    chk("sub_r_lit", 32'(ram_out), 32'(8'hFE));
    chk("sub_z_lit", 32'(zero), 32'(0));
    step();
    chk("str_ram_lit", 32'(env_ram[0]), 32'(8'hFE));
    force_wait = -1;

    // A=0xFF + B=1 wraps to zero
    clear_mem();
    rom[0] = 8'h10; rom[1] = 8'h31; rom[2] = 8'h40;
    env_ram[0] = 8'hFF; m_ram[0] = 8'hFF;
    do_reset();
    repeat (3) step();
    chk("add_wrap_r_lit", 32'(ram_out), 32'(0));
    chk("add_wrap_z_lit", 32'(zero), 32'(1));

    // JFZ n=2 at PC=10 with Z=1
    clear_mem();
    rom[10] = 8'h92;
    do_reset();
    repeat (11) step();
    chk("jfz_lit", 32'(code_address), 32'(13));

    // JBZ n=2 at PC=2 wraps backwards
    clear_mem();
    rom[2] = 8'hA2;
    do_reset();
    repeat (3) step();
    chk("jbz_wrap_lit", 32'(code_address), 32'(8'hFF));

    // four CALLs fill the stack, the fifth faults
    clear_mem();
    for (int i = 0; i < 5; i++) rom[i] = 8'hB0;
    do_reset();
    repeat (4) step();
    chk("call4_pc_lit", 32'(code_address), 32'(4));
    chk("call4_nofault_lit", 32'(fault), 32'(0));
    step();
    chk("call5_fault_lit", 32'(fault), 32'(1));
    chk("call5_pc_lit", 32'(code_address), 32'(4));
    repeat (5) step();

    // RET on empty stack
    clear_mem();
    rom[0] = 8'hC0;
    do_reset();
    step();
    chk("ret_empty_fault_lit", 32'(fault), 32'(1));
    chk("ret_empty_pc_lit", 32'(code_address), 32'(0));

    // CALL/RET round trip, then HALT
    clear_mem();
    rom[7] = 8'hB3; rom[11] = 8'hC0; rom[8] = 8'hF0;
    do_reset();
    repeat (8) step();
    chk("call_pc_lit", 32'(code_address), 32'(11));
    step();
    chk("ret_pc_lit", 32'(code_address), 32'(8));
    step();
    chk("halt_lit", 32'(halted), 32'(1));
    chk("halt_pc_lit", 32'(code_address), 32'(9));
    repeat (20) step();

    // reset in the middle of a memory wait
    clear_mem();
    rom[0] = 8'h31; rom[1] = 8'h49; rom[2] = 8'h10;
    do_reset();
    repeat (2) step();
    chk("pre_rst_z_lit", 32'(zero), 32'(0));
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_mid_req", 32'(mem_req), 32'(0));
    chk("rst_mid_pc", 32'(code_address), 32'(0));
    chk("rst_mid_z", 32'(zero), 32'(1));
    chk("rst_mid_r", 32'(ram_out), 32'(0));
    chk("rst_mid_state", 32'(dbg_state), 32'(ST_FETCH));

    // randomized programs
    for (int prog = 0; prog < 25; prog++) begin
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        if (b[7:4] == 4'hF && $urandom_range(0, 7) != 0) b[7:4] = 4'h4;
        if (b[7:4] == 4'hC && $urandom_range(0, 1) == 0) b[7:4] = 4'h3;
        rom[i] = b;
        b = 8'($urandom);
        env_ram[i] = b;
        m_ram[i] = b;
      end
      do_reset();
      for (int s = 0; s < 80; s++) step();
    end

    // 16-bit data / 12-bit address instance
    for (int i = 0; i < 256; i++) rom2[i] = 8'h00;
    for (int i = 0; i < 4096; i++) ram2[i] = 16'h0000;
    ram2[0] = 16'hABCD;
    ram2[1] = 16'h0FFF;
    rom2[0] = 8'h10; rom2[1] = 8'h48; rom2[2] = 8'h60; rom2[3] = 8'hF0;
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c < 60 && !halted2; c++) @(negedge clk);
    chk("w16_halt1", 32'(halted2), 32'(1));
    chk("w16_setp_lit", 32'(data_address2), 32'(12'hBCD));
    chk("w16_r_lit", 32'(ram_out2), 32'(16'hABCD));
    rom2[0] = 8'hD0; rom2[1] = 8'h10; rom2[2] = 8'h48; rom2[3] = 8'h60;
    rom2[4] = 8'hD0; rom2[5] = 8'hF0;
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c < 60 && !halted2; c++) @(negedge clk);
    chk("w16_halt2", 32'(halted2), 32'(1));
    chk("w16_incp_wrap_lit", 32'(data_address2), 32'(0));
    chk("w16_r2_lit", 32'(ram_out2), 32'(16'h0FFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
